dcache_store_buffer: RTL
========================

Name: dcache_store_buffer

Overview:
- Committed-store FIFO between the LSQ commit port and the dcache controller's store port.
- Absorbs retired stores and drains them one at a time on the controller's st_en/st_addr/st_data interface; an entry pops when the controller returns st_valid.
- Gives pending loads priority, with a bounded starvation limit.
- Searches buffered stores for load-address conflicts and, optionally, forwards data to those loads.

Parameters:
DEPTH, 8, number of store entries (power of 2, >=2)
HIGH_WATER, 6, occupancy at or above which loads lose priority
MAX_DEFER, 4, max consecutive cycles a head store may be deferred for loads

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clock)
lsq2sb_st_en  in  1  commit a store this cycle
lsq2sb_st_addr  in  64  store address (quadword; bits [2:0] ignored)
lsq2sb_st_data  in  64  store data
sb2lsq_ready  out  1  buffer not full; a commit is accepted only when high
lsq2sb_rd_en  in  1  a load is requesting the controller this cycle
lsq2sb_rd_addr  in  64  load address for conflict search
sb2lsq_fwd_hit  out  1  forwarded data valid (see Optional Feature)
sb2lsq_fwd_data  out  64  forwarded store data
sb2lsq_ld_conflict  out  1  load must stall; matching store still buffered
sb2ctr_st_en  out  1  store request to dcache controller
sb2ctr_st_addr  out  64  head entry address
sb2ctr_st_data  out  64  head entry data
ctr2sb_st_valid  in  1  controller/memory accepted the head store this cycle
sb_empty  out  1  count == 0

Behaviour:
- Storage: circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits.
- Reset (reset==0 at posedge): count=0, head=tail=0, state=IDLE, defer_cnt=0.
  - All entries are discarded, including one mid-issue.
  - Resulting outputs: sb2lsq_ready=1, sb_empty=1, sb2ctr_st_en=0, fwd_hit=0, fwd_data=0, ld_conflict=0.
  - sb2ctr_st_addr/data are don't-care while st_en=0 but read as 0 after reset.
- Push: lsq2sb_st_en & sb2lsq_ready writes entry[tail] and increments tail. A commit while full is ignored; the LSQ must not do this, and the bench asserts it never happens.
- sb2lsq_ready = (count != DEPTH). It is not relaxed by a same-cycle pop, so there is no combinational path from ctr2sb_st_valid.
- Pop: sb2ctr_st_en & ctr2sb_st_valid increments head. Simultaneous push and pop leaves count unchanged.
- ctr2sb_st_valid while st_en=0 is ignored.
- Latency: a store pushed into an empty buffer is visible on sb2ctr_st_en no earlier than the next cycle (state is registered).
- FSM states: IDLE, DEFER, ISSUE. Evaluated on each posedge using the next-count value cn.
  - IDLE -> when cn>0: DEFER if lsq2sb_rd_en & cn<HIGH_WATER, else ISSUE.
  - DEFER -> st_en=0; defer_cnt increments each cycle.
    - Goes to ISSUE when !lsq2sb_rd_en, or count>=HIGH_WATER, or defer_cnt==MAX_DEFER-1.
  - ISSUE -> st_en=1; addr/data = entry[head], held stable until accepted.
    - On accept, defer_cnt is cleared.
    - Then: cn==0 -> IDLE; else DEFER if lsq2sb_rd_en & cn<HIGH_WATER; else stay in ISSUE.
  - ISSUE is never abandoned without an accept.
- A head store is therefore delayed at most MAX_DEFER cycles by loads.
- Conflict search (combinational): compare lsq2sb_rd_addr[63:3] against addr[63:3] of every valid entry, including the head being issued.
  - If several entries match, the youngest (closest to tail) wins.
  - Search is active only when lsq2sb_rd_en=1; otherwise all search outputs are 0.

Optional Feature:
- Macro: DCACHE_SB_FWD_EN.
- Defined: on a match, fwd_hit=1, fwd_data=youngest matching entry's data, ld_conflict=0.
- Undefined: fwd_hit=0 and fwd_data=0 permanently; any match sets ld_conflict=1; no data mux is synthesised.

Decomposition:
- Shared package/header:
  - SB state encodings (IDLE=2'd0, DEFER=2'd1, ISSUE=2'd2).
  - Quadword address slice constant (bit 3 upward).
  - Existing TRUE/FALSE and SD delay macros.
- One natural sub-module: dcache_sb_match.
  - Parameterised youngest-match priority search over DEPTH entries.
  - Takes entry valid mask, addresses, data, head pointer and load address.
  - Returns hit and data.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-ISSUE with 3 entries -> next cycle sb_empty=1, st_en=0, ready=1; previously buffered stores never reappear.
- Fill and drain: push 8 stores (addr 0x100+8i, data i), rd_en=0, st_valid held 0 -> ready=0 after the 8th push and a 9th commit is ignored.
  - Then assert st_valid every cycle -> stores emerge in order 0..7, one per cycle, and sb_empty=1 after the last.
- Load priority and starvation: 2 entries, rd_en=1 continuously -> st_en stays 0 for exactly 4 cycles, then st_en=1 until st_valid.
  - Same test with count=6 -> st_en=1 immediately, no deferral.
- Simultaneous push/pop: count=3 in ISSUE, push and st_valid in the same cycle -> count stays 3, head advances, new entry lands at tail; repeat across pointer wrap (tail 7 -> 0).
- Forwarding (macro defined): push addr 0x208 data 0xAA, then 0x20C data 0xBB; rd_addr=0x208 -> fwd_hit=1, fwd_data=0xBB, ld_conflict=0.
  - rd_addr=0x210 -> fwd_hit=0, ld_conflict=0.
- Conflict (macro undefined): same stimulus with rd_addr=0x208 -> ld_conflict=1, fwd_hit=0, fwd_data=0; conflict clears the cycle after that entry pops.

Source files
------------

// File: rtl/dcache_store_buffer_pkg.sv
// Shared definitions for the dcache store buffer: FSM state encodings,
// the quadword address slice, and the common TRUE/FALSE/SD macros.
// Optional build macro used by the top: DCACHE_SB_FWD_EN (store-to-load forwarding).

`ifndef DCACHE_SB_COMMON_MACROS
`define DCACHE_SB_COMMON_MACROS
`define TRUE  1'b1
`define FALSE 1'b0
`define SD
`endif

package dcache_store_buffer_pkg;

  // Address/data widths of the store path
  localparam int SB_ADDR_W = 64;
  localparam int SB_DATA_W = 64;

  // Stores are quadword granular: address bits below this index are ignored
  // when comparing a load against buffered stores.
  localparam int SB_QW_LSB = 3;

  // Issue FSM states
  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DEFER = 2'd1,
    SB_ISSUE = 2'd2
  } sb_state_e;

endpackage

// File: rtl/dcache_store_buffer_if.sv
// Bus bundle for the store buffer: LSQ commit/search side, dcache
// controller store side, and a debug view of the issue FSM.
//
// Handshakes:
//   commit : a store is taken on a rising clock edge when lsq2sb_st_en and
//            sb2lsq_ready are both high. sb2lsq_ready depends only on the
//            registered occupancy, never on ctr2sb_st_valid.
//   drain  : sb2ctr_st_en/addr/data are registered and held stable until the
//            controller answers with ctr2sb_st_valid in the same cycle;
//            ctr2sb_st_valid is ignored while sb2ctr_st_en is low.

interface dcache_store_buffer_if #(
  parameter int DEPTH = 8
);
  import dcache_store_buffer_pkg::*;

  // LSQ commit port
  logic                 lsq2sb_st_en;
  logic [SB_ADDR_W-1:0] lsq2sb_st_addr;
  logic [SB_DATA_W-1:0] lsq2sb_st_data;
  logic                 sb2lsq_ready;

  // LSQ load search port
  logic                 lsq2sb_rd_en;
  logic [SB_ADDR_W-1:0] lsq2sb_rd_addr;
  logic                 sb2lsq_fwd_hit;
  logic [SB_DATA_W-1:0] sb2lsq_fwd_data;
  logic                 sb2lsq_ld_conflict;

  // dcache controller store port
  logic                 sb2ctr_st_en;
  logic [SB_ADDR_W-1:0] sb2ctr_st_addr;
  logic [SB_DATA_W-1:0] sb2ctr_st_data;
  logic                 ctr2sb_st_valid;

  // Status and debug
  logic                 sb_empty;
  sb_state_e            dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;

  // The store buffer itself
  modport slave (
    input  lsq2sb_st_en, lsq2sb_st_addr, lsq2sb_st_data,
    input  lsq2sb_rd_en, lsq2sb_rd_addr,
    input  ctr2sb_st_valid,
    output sb2lsq_ready,
    output sb2lsq_fwd_hit, sb2lsq_fwd_data, sb2lsq_ld_conflict,
    output sb2ctr_st_en, sb2ctr_st_addr, sb2ctr_st_data,
    output sb_empty, dbg_state, dbg_count
  );

  // The surrounding LSQ / controller environment
  modport master (
    output lsq2sb_st_en, lsq2sb_st_addr, lsq2sb_st_data,
    output lsq2sb_rd_en, lsq2sb_rd_addr,
    output ctr2sb_st_valid,
    input  sb2lsq_ready,
    input  sb2lsq_fwd_hit, sb2lsq_fwd_data, sb2lsq_ld_conflict,
    input  sb2ctr_st_en, sb2ctr_st_addr, sb2ctr_st_data,
    input  sb_empty, dbg_state, dbg_count
  );

endinterface

// File: rtl/dcache_sb_match.sv
// Youngest-match search of a load address against the buffered stores.
// Entries are walked from head (oldest) towards tail (youngest); a later
// match overrides an earlier one, so the youngest matching store wins.
// The data mux only exists when FWD_EN is set.

module dcache_sb_match
  import dcache_store_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter bit FWD_EN = 1'b0
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [SB_ADDR_W-1:0]     addr_i [DEPTH],
  input  logic [SB_DATA_W-1:0]     data_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [SB_ADDR_W-1:0]     ld_addr_i,
  output logic                     hit_o,
  output logic [SB_DATA_W-1:0]     data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] idx;
  logic [AW-1:0] sel_idx;
  logic          unused_lo;

  // Age-ordered scan: oldest first so the last hit seen is the youngest
  always_comb begin
    hit_o   = 1'b0;
    sel_idx = head_i;
    idx     = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + AW'(k);
      if (valid_i[idx] &&
          (addr_i[idx][SB_ADDR_W-1:SB_QW_LSB] == ld_addr_i[SB_ADDR_W-1:SB_QW_LSB])) begin
        hit_o   = 1'b1;
        sel_idx = idx;
      end
    end
  end

  // Byte-offset bits never take part in the quadword compare
  always_comb begin
    unused_lo = ^ld_addr_i[SB_QW_LSB-1:0];
    for (int i = 0; i < DEPTH; i++) begin
      unused_lo = unused_lo ^ (^addr_i[i][SB_QW_LSB-1:0]);
    end
  end

  generate
    if (FWD_EN) begin : g_fwd
      assign data_o = hit_o ? data_i[sel_idx] : '0;
    end else begin : g_nofwd
      logic unused_data;
      // Without forwarding the data array and selected index are not consumed
      always_comb begin
        unused_data = ^sel_idx;
        for (int i = 0; i < DEPTH; i++) begin
          unused_data = unused_data ^ (^data_i[i]);
        end
      end
      assign data_o = '0;
    end
  endgenerate

endmodule

// File: rtl/dcache_store_buffer.sv
// Committed-store FIFO between the LSQ commit port and the dcache
// controller's store port. Stores drain one at a time from the head; loads
// may defer the head store for at most MAX_DEFER cycles, and not at all once
// occupancy reaches HIGH_WATER. Loads are searched against every buffered
// store; with DCACHE_SB_FWD_EN defined the youngest match forwards its data,
// otherwise any match raises ld_conflict.

module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int HIGH_WATER = 6,
  parameter int MAX_DEFER  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  dcache_store_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(MAX_DEFER) + 1;

`ifdef DCACHE_SB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Entry storage (not reset; validity comes from head/count)
  logic [SB_ADDR_W-1:0] addr_q [DEPTH];
  logic [SB_DATA_W-1:0] data_q [DEPTH];

  // Pointers and occupancy
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Issue FSM
  sb_state_e     state_q;
  logic [DW-1:0] defer_cnt_q;
  logic          st_en_q;

  // Handshake and search helpers
  logic                 ready;
  logic                 push;
  logic                 pop;
  logic                 below_hw;
  logic [AW-1:0]        offset;
  logic [DEPTH-1:0]     valid;
  logic                 m_hit;
  logic [SB_DATA_W-1:0] m_data;

  // Push/pop qualification and next occupancy (cn)
  always_comb begin
    ready    = (count_q != CW'(DEPTH));
    push     = bus.lsq2sb_st_en & ready;
    pop      = st_en_q & bus.ctr2sb_st_valid;
    count_d  = count_q + CW'(push) - CW'(pop);
    below_hw = (count_d < CW'(HIGH_WATER));
  end

  // Entry write at tail
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= bus.lsq2sb_st_addr;
      data_q[tail_q] <= bus.lsq2sb_st_data;
    end
  end

  // Head/tail pointers and count; reset discards every entry
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Issue FSM with registered st_en; loads may defer the head store
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= SB_IDLE;
      st_en_q     <= `FALSE;
      defer_cnt_q <= '0;
    end else begin
      case (state_q)
        SB_IDLE: begin
          if (count_d != '0) begin
            if (bus.lsq2sb_rd_en && below_hw) begin
              state_q <= SB_DEFER;
              st_en_q <= `FALSE;
            end else begin
              state_q <= SB_ISSUE;
              st_en_q <= `TRUE;
            end
          end
        end
        SB_DEFER: begin
          // Leave when loads go away, the buffer fills up, or the budget runs out
          if (!bus.lsq2sb_rd_en || !below_hw ||
              (defer_cnt_q == DW'(MAX_DEFER - 1))) begin
            state_q <= SB_ISSUE;
            st_en_q <= `TRUE;
          end else begin
            defer_cnt_q <= defer_cnt_q + DW'(1);
          end
        end
        SB_ISSUE: begin
          // Only an accept can move the FSM out of ISSUE
          if (bus.ctr2sb_st_valid) begin
            defer_cnt_q <= '0;
            if (count_d == '0) begin
              state_q <= SB_IDLE;
              st_en_q <= `FALSE;
            end else if (bus.lsq2sb_rd_en && below_hw) begin
              state_q <= SB_DEFER;
              st_en_q <= `FALSE;
            end
          end
        end
        default: begin
          state_q     <= SB_IDLE;
          st_en_q     <= `FALSE;
          defer_cnt_q <= '0;
        end
      endcase
    end
  end

  // Valid mask: entry i is live when its distance from head is below count
  always_comb begin
    offset = '0;
    valid  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = AW'(i) - head_q;
      valid[i] = ({1'b0, offset} < count_q);
    end
  end

  dcache_sb_match #(
    .DEPTH  (DEPTH),
    .FWD_EN (FWD_EN)
  ) u_match (
    .valid_i   (valid),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .head_i    (head_q),
    .ld_addr_i (bus.lsq2sb_rd_addr),
    .hit_o     (m_hit),
    .data_o    (m_data)
  );

  // Load search results, only while a load is presented
  always_comb begin
`ifdef DCACHE_SB_FWD_EN
    bus.sb2lsq_fwd_hit     = bus.lsq2sb_rd_en & m_hit;
    bus.sb2lsq_fwd_data    = (bus.lsq2sb_rd_en & m_hit) ? m_data : '0;
    bus.sb2lsq_ld_conflict = 1'b0;
`else
    bus.sb2lsq_fwd_hit     = 1'b0;
    bus.sb2lsq_fwd_data    = '0;
    bus.sb2lsq_ld_conflict = bus.lsq2sb_rd_en & m_hit;
`endif
  end

`ifndef DCACHE_SB_FWD_EN
  logic unused_m_data;
  assign unused_m_data = ^m_data;
`endif

  // Store port: head entry while issuing, zero otherwise
  assign bus.sb2ctr_st_en   = st_en_q;
  assign bus.sb2ctr_st_addr = st_en_q ? addr_q[head_q] : '0;
  assign bus.sb2ctr_st_data = st_en_q ? data_q[head_q] : '0;

  // Status and debug view
  assign bus.sb2lsq_ready = ready;
  assign bus.sb_empty     = (count_q == '0);
  assign bus.dbg_state    = state_q;
  assign bus.dbg_count    = count_q;

endmodule
